drum_step_sequencer: RTL and testbench



---
 rtl/drum_pkg.sv | 42 ++++
 rtl/drum_step_timer.sv | 29 ++
 rtl/drum_step_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_drum_step_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared constants and types for the drum step sequencer: register map,
// CTRL bit positions, strike request struct and the run-state encoding.
package drum_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_PATTERN = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_RESTART = 2;

  localparam int NUM_CH   = 2;
  localparam int PERIOD_W = 24;

  typedef struct packed {
    logic              valid;
    logic [NUM_CH-1:0] mask;
  } strike_t;

  // IDLE: stopped at step 0; ARM: step 0 evaluated on the next edge;
  // RUN: stepping; PAUSE: stopped mid-loop, resumes where it left off.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } run_state_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/drum_step_timer.sv
// Loadable down-counter that sets the step interval. o_tick marks the last
// clock of an interval; the counter reloads itself on that same edge.
module drum_step_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tick
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      if (r_count == '0) r_count <= i_load_val;
      else               r_count <= r_count - 1'b1;
    end
  end

  assign o_tick = i_en & (r_count == '0);

endmodule

// File: rtl/drum_step_sequencer.sv
// Avalon-MM programmable 16-step, 2-channel drum pattern player that issues
// strike requests (channel masks) to the strike stage over valid/ready.
module drum_step_sequencer
  import drum_pkg::*;
#(
  parameter int          NUM_STEPS  = 16,
  parameter logic [23:0] PERIOD_RST = 24'd49999,
  parameter logic [23:0] MIN_PERIOD = 24'd15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         AVL_READ,
  input  logic                         AVL_WRITE,
  input  logic                         AVL_CS,
  input  logic [3:0]                   AVL_BYTE_EN,
  input  logic [1:0]                   AVL_ADDR,
  input  logic [31:0]                  AVL_WRITEDATA,
  output logic [31:0]                  AVL_READDATA,
  output logic                         strike_valid,
  output logic [NUM_CH-1:0]            strike_mask,
  input  logic                         strike_ready,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         running,
  output run_state_t                   dbg_state
);

  localparam int IDX_W = $clog2(NUM_STEPS);

  run_state_t              r_state, w_next;
  logic                    r_oneshot;
  logic [PERIOD_W-1:0]     r_period;
  logic [31:0]             r_pattern;
  logic [IDX_W-1:0]        r_step_idx;
  strike_t                 r_strike;
  logic [7:0]              r_overrun;
  logic [31:0]             r_rdata;

  logic                    w_wr, w_rd, w_ctrl_wr, w_run_wr, w_restart;
  logic                    w_status_wr, w_last, w_tick, w_running;
  logic                    w_eval_first, w_advance, w_finish, w_eval;
  logic [IDX_W-1:0]        w_eval_idx;
  logic [NUM_CH-1:0]       w_step_mask;
  logic [NUM_STEPS-1:0]    w_ch0, w_ch1;
  logic [PERIOD_W-1:0]     w_period_merged, w_period_new;
  logic [31:0]             w_status;

  assign w_wr        = AVL_CS & AVL_WRITE;
  assign w_rd        = AVL_CS & AVL_READ;
  assign w_ctrl_wr   = w_wr & (AVL_ADDR == ADDR_CTRL) & AVL_BYTE_EN[0];
  assign w_run_wr    = AVL_WRITEDATA[CTRL_RUN];
  assign w_restart   = w_ctrl_wr & AVL_WRITEDATA[CTRL_RESTART];
  assign w_status_wr = w_wr & (AVL_ADDR == ADDR_STATUS);
  assign w_last      = (r_step_idx == IDX_W'(NUM_STEPS - 1));
  assign w_running   = (r_state == ST_ARM) || (r_state == ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Restart and RUN writes take priority over the interval tick.
  always_comb begin
    w_next       = r_state;
    w_eval_first = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ctrl_wr && w_run_wr) w_next = ST_ARM;
      end
      ST_PAUSE: begin
        if (w_ctrl_wr) begin
          if (w_run_wr)       w_next = w_restart ? ST_ARM : ST_RUN;
          else if (w_restart) w_next = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (w_ctrl_wr && !w_run_wr) begin
          w_next = ST_IDLE;
        end else if (!w_restart) begin
          w_next       = ST_RUN;
          w_eval_first = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_ctrl_wr && !w_run_wr) begin
          w_next = w_restart ? ST_IDLE : ST_PAUSE;
        end else if (w_restart) begin
          w_next = ST_ARM;
        end else if (w_tick) begin
          if (w_last && r_oneshot) begin
            w_next   = ST_IDLE;
            w_finish = 1'b1;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  drum_step_timer #(.W(PERIOD_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_en       (r_state == ST_RUN),
    .i_load     (w_eval_first | w_restart),
    .i_load_val (r_period),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_period_merged = r_period;
    for (int b = 0; b < 3; b++) begin
      if (AVL_BYTE_EN[b]) w_period_merged[8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
    end
  end
  assign w_period_new = (w_period_merged < MIN_PERIOD) ? MIN_PERIOD : w_period_merged;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oneshot <= 1'b0;
      r_period  <= PERIOD_RST;
      r_pattern <= '0;
    end else begin
      if (w_ctrl_wr) r_oneshot <= AVL_WRITEDATA[CTRL_ONESHOT];
      if (w_wr && (AVL_ADDR == ADDR_PERIOD)) r_period <= w_period_new;
      if (w_wr && (AVL_ADDR == ADDR_PATTERN))
        r_pattern <= be_merge(r_pattern, AVL_WRITEDATA, AVL_BYTE_EN);
    end
  end

  // The advancing step is evaluated on the same edge that moves step_idx.
  assign w_ch0       = r_pattern[NUM_STEPS-1:0];
  assign w_ch1       = r_pattern[2*NUM_STEPS-1:NUM_STEPS];
  assign w_eval      = w_eval_first | w_advance;
  assign w_eval_idx  = w_advance ? r_step_idx + 1'b1 : r_step_idx;
  assign w_step_mask = {w_ch1[w_eval_idx], w_ch0[w_eval_idx]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_idx <= '0;
    end else if (w_restart || w_finish) begin
      r_step_idx <= '0;
    end else if (w_advance) begin
      r_step_idx <= r_step_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strike <= '0;
    end else if (w_restart) begin
      r_strike <= '0;
    end else if (w_eval && (w_step_mask != '0)) begin
      r_strike.valid <= 1'b1;
      r_strike.mask  <= w_step_mask;
    end else if (r_strike.valid && strike_ready) begin
      r_strike <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= '0;
    end else if (w_status_wr) begin
      r_overrun <= '0;
    end else if (w_eval && (w_step_mask != '0) && r_strike.valid && !strike_ready &&
                 (r_overrun != 8'hFF)) begin
      r_overrun <= r_overrun + 1'b1;
    end
  end

  assign w_status = {16'd0, r_overrun, 2'd0, r_strike.valid, w_running, 4'(r_step_idx)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      case (AVL_ADDR)
        ADDR_CTRL:    r_rdata <= {29'd0, 1'b0, r_oneshot, w_running};
        ADDR_PERIOD:  r_rdata <= {8'd0, r_period};
        ADDR_PATTERN: r_rdata <= r_pattern;
        default:      r_rdata <= w_status;
      endcase
    end
  end

  assign AVL_READDATA = r_rdata;
  assign strike_valid = r_strike.valid;
  assign strike_mask  = r_strike.mask;
  assign step_idx     = r_step_idx;
  assign running      = w_running;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed bench for drum_step_sequencer: register access, step timing,
// overrun, one-shot, pause/resume and asynchronous reset mid-run.
module tb_drum_step_sequencer;
  import drum_pkg::*;

  logic        clk;
  logic        reset;
  logic        AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]  AVL_BYTE_EN;
  logic [1:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic        strike_valid;
  logic [1:0]  strike_mask;
  logic        strike_ready;
  logic [3:0]  step_idx;
  logic        running;
  run_state_t  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  drum_step_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_CS        (AVL_CS),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .strike_valid  (strike_valid),
    .strike_mask   (strike_mask),
    .strike_ready  (strike_ready),
    .step_idx      (step_idx),
    .running       (running),
    .dbg_state     (dbg_state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Called at a negedge; the access is captured on the following posedge.
  task automatic avl_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge clk);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_WRITEDATA = '0; AVL_BYTE_EN = '0;
  endtask

  task automatic avl_read(input logic [1:0] a, output logic [31:0] d);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(negedge clk);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    n_cmp++;
    if (AVL_READDATA !== 32'd0 || strike_valid !== 1'b0 || strike_mask !== 2'b00 ||
        step_idx !== 4'd0 || running !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_outputs: got rd=%h v=%b m=%b idx=%0d run=%b st=%0d exp all zero",
               AVL_READDATA, strike_valid, strike_mask, step_idx, running, dbg_state);
    end
    reset = 1'b0;
    avl_read(ADDR_PERIOD, rd);
    n_cmp++;
    if (rd !== 32'h0000_C34F) begin n_err++; $display("FAIL reset_period: got %h exp 0000c34f", rd); end
    avl_read(ADDR_CTRL, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %h exp 0", rd); end
    avl_read(ADDR_PATTERN, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_err++; $display("FAIL reset_pattern: got %h exp 0", rd); end
    avl_read(ADDR_STATUS, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_err++; $display("FAIL reset_status: got %h exp 0", rd); end
  endtask

  task automatic test_period_clamp();
    logic [31:0] rd;
    avl_write(ADDR_PERIOD, 32'h3, 4'hF);
    avl_read(ADDR_PERIOD, rd);
    n_cmp++;
    if (rd !== 32'h0000_000F) begin n_err++; $display("FAIL period_clamp_low: got %h exp 0000000f", rd); end
    avl_write(ADDR_PERIOD, 32'hFFFF_FFFF, 4'hF);
    avl_read(ADDR_PERIOD, rd);
    n_cmp++;
    if (rd !== 32'h00FF_FFFF) begin n_err++; $display("FAIL period_upper_byte: got %h exp 00ffffff", rd); end
    avl_write(ADDR_PERIOD, 32'h0000_00AB, 4'b0001);
    avl_read(ADDR_PERIOD, rd);
    n_cmp++;
    if (rd !== 32'h00FF_FFAB) begin n_err++; $display("FAIL period_byte_en: got %h exp 00ffffab", rd); end
    avl_write(ADDR_PERIOD, 32'h0000_0100, 4'hF);
    avl_write(ADDR_PERIOD, 32'h0000_0000, 4'b0010);
    avl_read(ADDR_PERIOD, rd);
    n_cmp++;
    if (rd !== 32'h0000_000F) begin n_err++; $display("FAIL period_merged_clamp: got %h exp 0000000f", rd); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (AVL_READDATA !== 32'h0000_000F) begin
      n_err++; $display("FAIL readdata_hold: got %h exp 0000000f", AVL_READDATA);
    end
    avl_write(ADDR_PATTERN, 32'h1234_5678, 4'b0101);
    avl_read(ADDR_PATTERN, rd);
    n_cmp++;
    if (rd !== 32'h0034_0078) begin n_err++; $display("FAIL pattern_byte_en: got %h exp 00340078", rd); end
  endtask

  task automatic test_basic_loop();
    logic exp_v;
    strike_ready = 1'b1;
    avl_write(ADDR_PERIOD, 32'd15, 4'hF);
    avl_write(ADDR_PATTERN, 32'h0001_0001, 4'hF);
    avl_write(ADDR_CTRL, 32'h1, 4'hF);
    n_cmp++;
    if (running !== 1'b1 || strike_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_start: got run=%b v=%b exp run=1 v=0", running, strike_valid);
    end
    for (int t = 0; t < 272; t++) begin
      @(negedge clk);
      exp_v = (t == 0) || (t == 256);
      n_cmp++;
      if (strike_valid !== exp_v || strike_mask !== (exp_v ? 2'b11 : 2'b00) ||
          step_idx !== 4'((t / 16) % 16)) begin
        n_err++;
        $display("FAIL basic_loop t=%0d: got v=%b m=%b idx=%0d exp v=%b m=%b idx=%0d",
                 t, strike_valid, strike_mask, step_idx, exp_v, exp_v ? 2'b11 : 2'b00, (t / 16) % 16);
      end
    end
    avl_write(ADDR_CTRL, 32'h4, 4'hF);
    n_cmp++;
    if (running !== 1'b0 || step_idx !== 4'd0) begin
      n_err++; $display("FAIL basic_stop: got run=%b idx=%0d exp 0/0", running, step_idx);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    strike_ready = 1'b0;
    avl_write(ADDR_PATTERN, 32'h0000_FFFF, 4'hF);
    avl_write(ADDR_CTRL, 32'h1, 4'hF);
    repeat (33) @(negedge clk);
    n_cmp++;
    if (strike_valid !== 1'b1 || strike_mask !== 2'b01) begin
      n_err++; $display("FAIL overrun_pending: got v=%b m=%b exp v=1 m=01", strike_valid, strike_mask);
    end
    avl_read(ADDR_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0232) begin n_err++; $display("FAIL overrun_status: got %h exp 00000232", rd); end
    strike_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (strike_valid !== 1'b0) begin n_err++; $display("FAIL overrun_accept: got v=%b exp 0", strike_valid); end
    avl_write(ADDR_CTRL, 32'h4, 4'hF);
    avl_read(ADDR_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0200) begin n_err++; $display("FAIL overrun_after_stop: got %h exp 00000200", rd); end
    avl_write(ADDR_STATUS, 32'h0, 4'hF);
    avl_read(ADDR_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0000) begin n_err++; $display("FAIL overrun_clear: got %h exp 0", rd); end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    logic        exp_v, exp_run;
    logic [3:0]  exp_idx;
    strike_ready = 1'b1;
    avl_write(ADDR_PERIOD, 32'd20, 4'hF);
    avl_write(ADDR_PATTERN, 32'h8000_0000, 4'hF);
    avl_write(ADDR_CTRL, 32'h3, 4'hF);
    for (int t = 0; t < 360; t++) begin
      @(negedge clk);
      exp_v   = (t == 315);
      exp_run = (t < 336);
      exp_idx = (t < 336) ? 4'(t / 21) : 4'd0;
      n_cmp++;
      if (strike_valid !== exp_v || strike_mask !== (exp_v ? 2'b10 : 2'b00) ||
          running !== exp_run || step_idx !== exp_idx) begin
        n_err++;
        $display("FAIL oneshot t=%0d: got v=%b m=%b run=%b idx=%0d exp v=%b run=%b idx=%0d",
                 t, strike_valid, strike_mask, running, step_idx, exp_v, exp_run, exp_idx);
      end
    end
    avl_read(ADDR_CTRL, rd);
    n_cmp++;
    if (rd !== 32'h0000_0002) begin n_err++; $display("FAIL oneshot_ctrl: got %h exp 00000002", rd); end
    avl_write(ADDR_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_pause_resume();
    logic [3:0] exp_idx;
    strike_ready = 1'b1;
    avl_write(ADDR_PERIOD, 32'd15, 4'hF);
    avl_write(ADDR_PATTERN, 32'h0080_0080, 4'hF);
    avl_write(ADDR_CTRL, 32'h1, 4'hF);
    for (int t = 0; t < 116; t++) begin
      @(negedge clk);
      if (t == 112) begin
        n_cmp++;
        if (strike_valid !== 1'b1 || strike_mask !== 2'b11 || step_idx !== 4'd7) begin
          n_err++; $display("FAIL pause_step7_strike: got v=%b m=%b idx=%0d exp 1/11/7",
                            strike_valid, strike_mask, step_idx);
        end
      end
    end
    avl_write(ADDR_CTRL, 32'h0, 4'hF);
    for (int u = 0; u < 1000; u++) begin
      n_cmp++;
      if (step_idx !== 4'd7 || running !== 1'b0 || strike_valid !== 1'b0) begin
        n_err++; $display("FAIL pause_hold u=%0d: got idx=%0d run=%b v=%b exp 7/0/0",
                          u, step_idx, running, strike_valid);
      end
      @(negedge clk);
    end
    avl_write(ADDR_CTRL, 32'h1, 4'hF);
    for (int u = 0; u <= 20; u++) begin
      exp_idx = (u < 12) ? 4'd7 : 4'd8;
      n_cmp++;
      if (step_idx !== exp_idx || running !== 1'b1 || strike_valid !== 1'b0) begin
        n_err++; $display("FAIL resume u=%0d: got idx=%0d run=%b v=%b exp %0d/1/0",
                          u, step_idx, running, strike_valid, exp_idx);
      end
      @(negedge clk);
    end
    avl_write(ADDR_CTRL, 32'h4, 4'hF);
  endtask

  task automatic test_reset_midrun();
    logic [31:0] rd;
    strike_ready = 1'b0;
    avl_write(ADDR_PATTERN, 32'h0000_FFFF, 4'hF);
    avl_write(ADDR_CTRL, 32'h1, 4'hF);
    repeat ($urandom_range(2, 60)) @(negedge clk);
    n_cmp++;
    if (strike_valid !== 1'b1) begin n_err++; $display("FAIL midrun_pending: got v=%b exp 1", strike_valid); end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (AVL_READDATA !== 32'd0 || strike_valid !== 1'b0 || strike_mask !== 2'b00 ||
        step_idx !== 4'd0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_async_reset: got rd=%h v=%b m=%b idx=%0d run=%b exp all zero",
               AVL_READDATA, strike_valid, strike_mask, step_idx, running);
    end
    @(negedge clk);
    reset = 1'b0;
    avl_read(ADDR_PERIOD, rd);
    n_cmp++;
    if (rd !== 32'h0000_C34F) begin n_err++; $display("FAIL midrun_period: got %h exp 0000c34f", rd); end
    avl_read(ADDR_PATTERN, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_err++; $display("FAIL midrun_pattern: got %h exp 0", rd); end
    avl_read(ADDR_STATUS, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_err++; $display("FAIL midrun_status: got %h exp 0", rd); end
  endtask

  initial begin
    reset = 1'b0;
    AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
    AVL_BYTE_EN = '0; AVL_ADDR = '0; AVL_WRITEDATA = '0;
    strike_ready = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_period_clamp();
    test_basic_loop();
    test_overrun();
    test_oneshot();
    test_pause_resume();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
